// File: rtl/pe_cfg_pkg.sv
// Shared configuration layout for the PE compute slice: field offsets, ALU
// opcodes and crossbar source codes.
package pe_cfg_pkg;
  localparam int CFG_W       = 11;
  localparam int OP_LSB      = 0;
  localparam int OUT_SEL_BIT = 2;
  localparam int XSEL0_LSB   = 3;
  localparam int XSEL1_LSB   = 5;
  localparam int XSEL2_LSB   = 7;
  localparam int XSEL3_LSB   = 9;
  localparam int NUM_XOUT    = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2,
    ALU_AND = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_IN0 = 2'd0,
    SRC_IN1 = 2'd1,
    SRC_ALU = 2'd2,
    SRC_MEM = 2'd3
  } src_e;

  // Packed MSB-first, so this overlays cfg[10:0] bit for bit.
  typedef struct packed {
    logic [1:0] xsel3;
    logic [1:0] xsel2;
    logic [1:0] xsel1;
    logic [1:0] xsel0;
    logic       out_sel;
    alu_op_e    alu_op;
  } pe_cfg_t;
endpackage

// File: rtl/pe_xbar4x4.sv
// Combinational 4-to-4 crossbar: each output independently picks one of four
// sources through its own 2-bit select.
module pe_xbar4x4
  import pe_cfg_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [NUM_XOUT-1:0][W-1:0] src,
  input  logic [NUM_XOUT-1:0][1:0]   sel,
  output logic [NUM_XOUT-1:0][W-1:0] dout
);
  for (genvar k = 0; k < NUM_XOUT; k++) begin : g_out
    assign dout[k] = src[sel[k]];
  end
endmodule

// File: rtl/pe_alu_datapath.sv
// CGRA PE compute slice: crossbar-fed registered ALU, output select between
// ALU and memory return, configured through a chainable serial shift register.
module pe_alu_datapath
  import pe_cfg_pkg::*;
#(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_en,
  input  logic            config_in,
  output logic            config_out,
  input  logic [size-1:0] in0,
  input  logic [size-1:0] in1,
  input  logic [size-1:0] mem_rdata,
  output logic [size-1:0] mem_a,
  output logic [size-1:0] mem_b,
  output logic [size-1:0] out0
);
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [size-1:0]  alu_q, alu_d;
  pe_cfg_t          cfg;

  logic [NUM_XOUT-1:0][size-1:0] xsrc, xout;
  logic [NUM_XOUT-1:0][1:0]      xsel;
  logic [size-1:0]               op_a, op_b, prod;

  assign cfg        = pe_cfg_t'(cfg_q);
  assign config_out = cfg_q[CFG_W-1];

  // Source 2 is the registered ALU result, so feedback never closes a comb loop.
  assign xsrc[SRC_IN0] = in0;
  assign xsrc[SRC_IN1] = in1;
  assign xsrc[SRC_ALU] = alu_q;
  assign xsrc[SRC_MEM] = mem_rdata;
  assign xsel = {cfg.xsel3, cfg.xsel2, cfg.xsel1, cfg.xsel0};

  pe_xbar4x4 #(.W(size)) u_xbar (
    .src  (xsrc),
    .sel  (xsel),
    .dout (xout)
  );

  assign op_a  = xout[0];
  assign op_b  = xout[1];
  assign mem_a = xout[2];
  assign mem_b = xout[3];
  assign prod  = op_a * op_b;

  always_comb begin
    cfg_d = cfg_q;
    if (cfg_en) cfg_d = {cfg_q[CFG_W-2:0], config_in};
  end

  always_comb begin
    alu_d = '0;
    case (cfg.alu_op)
      ALU_ADD: alu_d = op_a + op_b;
      ALU_SUB: alu_d = op_a - op_b;
      ALU_MUL: alu_d = prod;
      ALU_AND: alu_d = op_a & op_b;
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q <= '0;
      alu_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      alu_q <= alu_d;
    end
  end

  assign out0 = cfg.out_sel ? mem_rdata : alu_q;
endmodule

// File: tb/tb_pe_alu_datapath.sv
// Directed bench for pe_alu_datapath: reset, ALU ops, accumulate, memory path
// and serial config chaining, with hand-computed expectations.
module tb_pe_alu_datapath;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_en;
  logic         config_in;
  logic         config_out;
  logic [W-1:0] in0, in1, mem_rdata;
  logic [W-1:0] mem_a, mem_b, out0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_alu_datapath #(.size(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_en     (cfg_en),
    .config_in  (config_in),
    .config_out (config_out),
    .in0        (in0),
    .in1        (in1),
    .mem_rdata  (mem_rdata),
    .mem_a      (mem_a),
    .mem_b      (mem_b),
    .out0       (out0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [10:0] w);
    for (int i = 10; i >= 0; i--) begin
      cfg_en    = 1'b1;
      config_in = w[i];
      tick();
    end
    cfg_en    = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_en = 1'b0; config_in = 1'b0;
    in0 = 32'd5; in1 = 32'd7; mem_rdata = 32'h99;
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      n_cmp++; if (out0 !== 32'd0) begin n_err++; $display("FAIL reset_out0 pass%0d got %h want 0", pass, out0); end
      n_cmp++; if (config_out !== 1'b0) begin n_err++; $display("FAIL reset_cfgout pass%0d got %b want 0", pass, config_out); end
      n_cmp++; if (mem_a !== 32'd5) begin n_err++; $display("FAIL reset_mem_a pass%0d got %h want 5", pass, mem_a); end
      n_cmp++; if (mem_b !== 32'd5) begin n_err++; $display("FAIL reset_mem_b pass%0d got %h want 5", pass, mem_b); end
      if (pass == 0) repeat (3) tick();
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu_op(input string name, input logic [10:0] w,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp);
    in0 = '0; in1 = '0; mem_rdata = '0;
    shift_word(w);
    in0 = a; in1 = b;
    tick();
    n_cmp++;
    if (out0 !== exp) begin n_err++; $display("FAIL %s got %h want %h", name, out0, exp); end
  endtask

  task automatic test_accumulate();
    logic [W-1:0] exp_seq [3];
    exp_seq[0] = 32'd3; exp_seq[1] = 32'd6; exp_seq[2] = 32'd9;
    in0 = '0; in1 = '0; mem_rdata = '0;
    do_reset();
    shift_word(11'h030);  // xsel0=ALU, xsel1=IN1, ADD; zero inputs keep alu_q at 0
    in1 = 32'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out0 !== exp_seq[i]) begin n_err++; $display("FAIL accum_%0d got %h want %h", i, out0, exp_seq[i]); end
    end
  endtask

  task automatic test_mem_path();
    in0 = '0; in1 = '0; mem_rdata = '0;
    shift_word(11'h204);  // xsel2=IN0, xsel3=IN1, out_sel=MEM
    in0 = 32'hA; in1 = 32'hB; mem_rdata = 32'h55;
    #1;
    n_cmp++; if (mem_a !== 32'hA) begin n_err++; $display("FAIL mem_a got %h want a", mem_a); end
    n_cmp++; if (mem_b !== 32'hB) begin n_err++; $display("FAIL mem_b got %h want b", mem_b); end
    n_cmp++; if (out0 !== 32'h55) begin n_err++; $display("FAIL mem_out0 got %h want 55", out0); end
  endtask

  task automatic test_chain();
    logic [10:0] w;
    w = 11'h5A3;
    shift_word(w);
    for (int i = 10; i >= 0; i--) begin
      n_cmp++;
      if (config_out !== w[i]) begin n_err++; $display("FAIL chain_bit%0d got %b want %b", i, config_out, w[i]); end
      cfg_en = 1'b1; config_in = 1'b0;
      tick();
    end
    cfg_en = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    in0 = 32'h11; in1 = 32'h22; mem_rdata = 32'h77;
    for (int i = 0; i < 5; i++) begin
      cfg_en = 1'b1; config_in = 1'b1;
      tick();
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (out0 !== 32'd0) begin n_err++; $display("FAIL midrst_out0 got %h want 0", out0); end
    n_cmp++; if (mem_a !== 32'h11) begin n_err++; $display("FAIL midrst_mem_a got %h want 11", mem_a); end
    n_cmp++; if (mem_b !== 32'h11) begin n_err++; $display("FAIL midrst_mem_b got %h want 11", mem_b); end
    cfg_en = 1'b0;
    tick();
    reset = 1'b1;
    // Any surviving partial bit would surface on config_out within 11 shifts.
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (config_out !== 1'b0) begin n_err++; $display("FAIL midrst_drain%0d got %b want 0", i, config_out); end
      cfg_en = 1'b1; config_in = 1'b0;
      tick();
    end
    cfg_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_op("add", 11'h020, 32'd5, 32'd7, 32'd12);
    test_alu_op("sub", 11'h021, 32'd3, 32'd5, 32'hFFFF_FFFE);
    test_alu_op("mul", 11'h022, 32'h1_0000, 32'h1_0001, 32'h1_0000);
    test_alu_op("and", 11'h023, 32'hF0F0, 32'hFF00, 32'hF000);
    test_accumulate();
    test_mem_path();
    test_chain();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
